// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then
// shifts one byte plus odd parity out on device-generated clocks and checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,   // must be at least 2
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KCLK_IN,
  input  logic       KDATA_IN,
  output logic       KCLK_OE,
  output logic       KDATA_OE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       TIMEOUT_ERR
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]  INH_DATA  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, INHIBIT, SEND, WAIT_IDLE} state_t;

  state_t             state_q, state_d;
  logic               kclk_meta_q, kclk_sync_q, kdata_meta_q, kdata_sync_q;
  logic               kclk_filt_q, kclk_filt_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic [7:0]         data_q, data_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               kclk_oe_q, kclk_oe_d;
  logic               kdata_oe_q, kdata_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic               to_err_q, to_err_d;
  logic               kclk_fall;
  logic               timeout;
  logic [15:0]        frame_bits;

  // Glitch filter: the level follows the synchronized clock only after a full run
  // of FILTER_LEN consecutive differing samples.
  always_comb begin
    kclk_filt_d = kclk_filt_q;
    filt_cnt_d  = '0;
    if (kclk_sync_q != kclk_filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        kclk_filt_d = kclk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign kclk_fall = kclk_filt_q & ~kclk_filt_d;

  // Index k holds the bit presented after falling edge k+1; the stop bit and the
  // padding above it are 1 so the data line is released.
  assign frame_bits = {7'h7F, ~^data_q, data_q};

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = '0;
    kclk_oe_d  = kclk_oe_q;
    kdata_oe_d = kdata_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    to_err_d   = to_err_q;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        // A request coinciding with the DONE pulse is still treated as busy.
        if (TX_START && !done_q) begin
          data_d     = TX_DATA;
          busy_d     = 1'b1;
          ack_err_d  = 1'b0;
          to_err_d   = 1'b0;
          kclk_oe_d  = 1'b1;
          kdata_oe_d = 1'b0;
          inh_cnt_d  = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_DATA) kdata_oe_d = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          kclk_oe_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (kclk_fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd10) begin
            ack_err_d = kdata_sync_q;
            state_d   = WAIT_IDLE;
          end else begin
            kdata_oe_d = ~frame_bits[bit_cnt_q];
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (kclk_sync_q && kdata_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (!kclk_fall) begin
          if (to_cnt_q == TO_LAST) timeout = 1'b1;
          else                     to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      kclk_oe_d  = 1'b0;
      kdata_oe_d = 1'b0;
      to_err_d   = 1'b1;
      ack_err_d  = 1'b0;
      done_d     = 1'b1;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      kclk_meta_q  <= 1'b1;
      kclk_sync_q  <= 1'b1;
      kdata_meta_q <= 1'b1;
      kdata_sync_q <= 1'b1;
      kclk_filt_q  <= 1'b1;
      filt_cnt_q   <= '0;
      data_q       <= '0;
      inh_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      kclk_oe_q    <= 1'b0;
      kdata_oe_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_err_q    <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      kclk_meta_q  <= KCLK_IN;
      kclk_sync_q  <= kclk_meta_q;
      kdata_meta_q <= KDATA_IN;
      kdata_sync_q <= kdata_meta_q;
      kclk_filt_q  <= kclk_filt_d;
      filt_cnt_q   <= filt_cnt_d;
      data_q       <= data_d;
      inh_cnt_q    <= inh_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      kclk_oe_q    <= kclk_oe_d;
      kdata_oe_q   <= kdata_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ack_err_q    <= ack_err_d;
      to_err_q     <= to_err_d;
    end
  end

  assign KCLK_OE     = kclk_oe_q;
  assign KDATA_OE    = kdata_oe_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ACK_ERR     = ack_err_q;
  assign TIMEOUT_ERR = to_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device that clocks
// the frame, reads bits on rising edges and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int FLEN = 4;
  localparam int TOUT = 2000;
  localparam int HALF = 40;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       TX_START = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       KCLK_OE, KDATA_OE, BUSY, DONE, ACK_ERR, TIMEOUT_ERR;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kclk_line, kdata_line;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int fall_cyc = 0;

  assign kclk_line  = ~(KCLK_OE | dev_clk_low);
  assign kdata_line = ~(KDATA_OE | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN(FLEN),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .KCLK_IN(kclk_line),
    .KDATA_IN(kdata_line),
    .KCLK_OE(KCLK_OE),
    .KDATA_OE(KDATA_OE),
    .TX_DATA(TX_DATA),
    .TX_START(TX_START),
    .BUSY(BUSY),
    .DONE(DONE),
    .ACK_ERR(ACK_ERR),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Expected device view of the frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    TX_DATA  = b;
    TX_START = 1'b1;
    tick(1);
    TX_START = 1'b0;
    check("busy_rise", 32'(BUSY), 32'd1);
    check("kclk_oe_rise", 32'(KCLK_OE), 32'd1);
    check("flags_cleared", 32'({ACK_ERR, TIMEOUT_ERR}), 32'd0);
  endtask

  task automatic device_xfer(input int last_edge, input bit do_ack, input int inject_after,
                             output logic [10:0] got);
    int inh;
    int first_d;
    inh     = 0;
    first_d = 0;
    got     = '1;
    while (KCLK_OE === 1'b1 && inh < 1000) begin
      inh++;
      if (KDATA_OE === 1'b1 && first_d == 0) first_d = inh;
      tick(1);
    end
    check("inhibit_len", 32'(inh), 32'(INH));
    check("start_bit_cycle", 32'(first_d), 32'(INH));
    check("send_entry_oe", 32'({KCLK_OE, KDATA_OE}), 32'b01);
    tick(20);
    got[0] = kdata_line;
    for (int k = 1; k <= 10 && k <= last_edge; k++) begin
      dev_clk_low = 1'b1;
      fall_cyc    = cyc;
      tick(HALF);
      dev_clk_low = 1'b0;
      got[k]      = kdata_line;
      if (k == inject_after) begin
        tick(20);
        TX_DATA  = 8'hAA;
        TX_START = 1'b1;
        tick(1);
        TX_START = 1'b0;
        check("inject_busy_held", 32'(BUSY), 32'd1);
        tick(HALF - 21);
      end else begin
        tick(HALF);
      end
    end
    if (last_edge >= 11) begin
      dev_clk_low  = 1'b1;
      dev_data_low = do_ack;
      tick(HALF);
      dev_clk_low = 1'b0;
      if (do_ack) begin
        tick(10);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input bit exp_ack, input bit exp_to,
                           input bit poke, output int done_at);
    int n;
    bit busy_ok;
    n       = 0;
    busy_ok = 1'b1;
    while (DONE !== 1'b1 && n < 5000) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      n++;
      tick(1);
    end
    done_at = cyc;
    check({tag, "_done_seen"}, 32'(DONE), 32'd1);
    check({tag, "_busy_until_done"}, 32'(busy_ok), 32'd1);
    check({tag, "_ack_err"}, 32'(ACK_ERR), 32'(exp_ack));
    check({tag, "_timeout_err"}, 32'(TIMEOUT_ERR), 32'(exp_to));
    check({tag, "_idle_outputs"}, 32'({BUSY, KCLK_OE, KDATA_OE}), 32'd0);
    if (poke) begin
      TX_DATA  = 8'h55;
      TX_START = 1'b1;
    end
    tick(1);
    TX_START = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(DONE), 32'd0);
    check({tag, "_flags_held"}, 32'({ACK_ERR, TIMEOUT_ERR}), 32'({exp_ack, exp_to}));
    if (poke) check({tag, "_start_in_done_ignored"}, 32'({BUSY, KCLK_OE}), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                           input int inject, input bit poke);
    logic [10:0] got;
    int d;
    start_tx(b);
    device_xfer(11, ack, inject, got);
    check({tag, "_frame"}, 32'(got), 32'(expected_frame(b)));
    wait_done(tag, !ack, 1'b0, poke, d);
    $display("txn %s: byte=%02h ack=%0d frame=%03h", tag, b, ack, got);
    tick(5);
  endtask

  initial begin
    logic [10:0] got;
    logic [7:0]  rb;
    bit          rack;
    int          d;
    int          el;
    int          d0;

    RESET = 1'b0;
    tick(3);
    check("reset_outputs", 32'({KCLK_OE, KDATA_OE, BUSY, DONE, ACK_ERR, TIMEOUT_ERR}), 32'd0);
    RESET = 1'b1;
    tick(3);

    run_frame("ed_ack", 8'hED, 1'b1, 0, 1'b0);
    run_frame("ff_ack", 8'hFF, 1'b1, 0, 1'b0);
    run_frame("01_ack", 8'h01, 1'b1, 0, 1'b0);
    run_frame("00_nack", 8'h00, 1'b0, 0, 1'b1);

    // Device goes silent after the fourth falling edge.
    start_tx(8'h5A);
    device_xfer(4, 1'b0, 0, got);
    wait_done("timeout", 1'b0, 1'b1, 1'b0, d);
    el = d - fall_cyc;
    check("timeout_latency_ok", 32'(el >= TOUT && el <= TOUT + 15), 32'd1);
    $display("txn timeout: byte=5a elapsed=%0d", el);
    tick(5);
    run_frame("f4_after_to", 8'hF4, 1'b1, 0, 1'b0);

    run_frame("3c_inject", 8'h3C, 1'b1, 3, 1'b0);

    // Reset asserted while the device holds the clock low for edge 6.
    start_tx(8'hED);
    device_xfer(5, 1'b0, 0, got);
    dev_clk_low = 1'b1;
    tick(10);
    check("pre_reset_busy", 32'(BUSY), 32'd1);
    d0    = done_cnt;
    RESET = 1'b0;
    #1;
    check("reset_mid_frame", 32'({KCLK_OE, KDATA_OE, BUSY, DONE}), 32'd0);
    tick(1);
    dev_clk_low = 1'b0;
    tick(3);
    RESET = 1'b1;
    tick(5);
    check("reset_no_done", 32'(done_cnt), 32'(d0));
    $display("txn reset_mid_frame: byte=ed");
    run_frame("ed_after_rst", 8'hED, 1'b1, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rb   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      run_frame("random", rb, rack, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
